// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_ITER_FAST_MUL_EN to compute multiplies in a single cycle instead.
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // resp_result stays stable while resp_valid is high and resp_ready is low.
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_nx;
    logic [2:0]          op_q, op_nx;
    logic                neg_q, neg_nx;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic [2*XLEN-1:0]   acc_q, acc_nx;
    logic [XLEN-1:0]     opnd_q, opnd_nx;
    logic [XLEN-1:0]     res_q, res_nx;

    logic                a_signed, b_signed, sa, sb, neg_in;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                is_ovf, is_dz;
    logic [XLEN:0]       mul_sum;
    logic [XLEN+1:0]     div_trial;
    logic [2*XLEN-1:0]   mul_step, div_step, step, prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, final_res;

`ifdef MULDIV_ITER_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_p;
`endif

    // Operand conditioning; MUL low bits are sign-agnostic so it runs unsigned.
    always_comb begin
        a_signed = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
        b_signed = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
        sa       = a_signed & req_a[XLEN-1];
        sb       = b_signed & req_b[XLEN-1];
        abs_a    = sa ? (~req_a + 1'b1) : req_a;
        abs_b    = sb ? (~req_b + 1'b1) : req_b;
        neg_in   = (req_op == 3'd6) ? sa : (sa ^ sb);
        is_dz    = req_op[2] && (req_b == '0);
        is_ovf   = ((req_op == 3'd4) || (req_op == 3'd6)) &&
                   (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == {XLEN{1'b1}});
    end

    // One iteration of each algorithm, plus sign-corrected final result.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
        div_step  = div_trial[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step      = op_q[2] ? div_step : mul_step;
        prod_fix  = neg_q ? (~step + 1'b1) : step;
        quo_fix   = neg_q ? (~step[XLEN-1:0] + 1'b1) : step[XLEN-1:0];
        rem_fix   = neg_q ? (~step[2*XLEN-1:XLEN] + 1'b1) : step[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:       final_res = prod_fix[XLEN-1:0];
            3'd4, 3'd5: final_res = quo_fix;
            3'd6, 3'd7: final_res = rem_fix;
            default:    final_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

`ifdef MULDIV_ITER_FAST_MUL_EN
    always_comb begin
        fast_a = {sa, req_a};
        fast_b = {sb, req_b};
        fast_p = fast_a * fast_b;
    end
`endif

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        neg_nx   = neg_q;
        cnt_nx   = cnt_q;
        acc_nx   = acc_q;
        opnd_nx  = opnd_q;
        res_nx   = res_q;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_nx  = req_op;
                    neg_nx = neg_in;
                    if (is_dz) begin
                        state_nx = DONE;
                        res_nx   = req_op[1] ? req_a : {XLEN{1'b1}};
                    end else if (is_ovf) begin
                        state_nx = DONE;
                        res_nx   = req_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_ITER_FAST_MUL_EN
                    end else if (!req_op[2]) begin
                        state_nx = DONE;
                        res_nx   = (req_op == 3'd0) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif
                    end else begin
                        state_nx = CALC;
                        cnt_nx   = {CNT_W{1'b1}};
                        acc_nx   = {{XLEN{1'b0}}, (req_op[2] ? abs_a : abs_b)};
                        opnd_nx  = req_op[2] ? abs_b : abs_a;
                    end
                end
            end
            CALC: begin
                acc_nx = step;
                cnt_nx = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_nx = DONE;
                    res_nx   = final_res;
                end
            end
            DONE: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            res_q  <= '0;
        end else begin
            state  <= state_nx;
            op_q   <= op_nx;
            neg_q  <= neg_nx;
            cnt_q  <= cnt_nx;
            acc_q  <= acc_nx;
            opnd_q <= opnd_nx;
            res_q  <= res_nx;
        end
    end

    assign req_ready   = (state == IDLE) && !flush && !rst;
    assign resp_valid  = (state == DONE);
    assign resp_result = res_q;
    assign busy        = (state != IDLE);
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative multi-cycle RV32M multiply/divide responder in the exec unit.
- The exec stage issues a request over a valid/ready handshake. This block computes over ~32 cycles and returns the result over a second valid/ready handshake.
- Replaces the single-cycle combinational M-extension path for timing-critical builds.
- Bit-exact with RISC-V spec M-extension semantics, including divide-by-zero and overflow results.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == XLEN.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  abort in-flight operation (pipeline kill).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_a  in  32  rs1 operand.
- req_b  in  32  rs2 operand.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  32  result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, req_ready=0 while rst held, resp_valid=0, resp_result=0, busy=0, counter=0, all datapath registers 0.
- req_ready = (state==IDLE) && !flush. Accept occurs at a rising edge where req_valid && req_ready.
- On accept, latch op, |a|, |b|, and the result sign:
  - signed ops use two's-complement absolute value; MULHSU treats b as unsigned.
  - quotient sign = sa^sb; remainder sign = sa.
- State IDLE:
  - DIV/DIVU/REM/REMU with b==0 -> DONE with result loaded directly: quotient 0xFFFFFFFF, remainder = a.
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF -> DONE: DIV gives 0x80000000, REM gives 0.
  - All other accepted ops -> CALC, counter = 31.
- State CALC:
  - Divide: one restoring step per cycle on a 64-bit remainder/quotient shift register.
  - Multiply: one shift-add step per cycle on a 64-bit product register, with a 33-bit accumulator so the carry is kept.
  - Counter decrements each cycle. At counter==0 the step completes, sign correction is applied (negate 64-bit product or quotient/remainder as latched), and the state goes to DONE with resp_result registered.
- Result selection:
  - MUL: low 32 bits of product.
  - MULH/MULHSU/MULHU: high 32 bits of product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- State DONE:
  - resp_valid=1; resp_result held stable until resp_valid && resp_ready.
  - On that handshake -> IDLE and resp_valid drops next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- Latency, measured from the accept edge to the edge where resp_valid first rises:
  - 33 cycles for normal ops.
  - 1 cycle for the div-by-zero and overflow shortcuts.
- flush:
  - Synchronous; any state -> IDLE next edge; resp_valid cleared; the result is discarded.
  - flush with req_valid in IDLE: no accept, because req_ready is low.
  - flush in DONE while resp_ready=1: flush wins and no response is delivered.
- Async rst mid-CALC: immediately returns to IDLE with all outputs at reset values.
- Back-to-back: at most one operation in flight; minimum issue interval is latency+1 cycles.

Optional Feature:
- Macro MULDIV_ITER_FAST_MUL_EN.
- When defined:
  - MUL/MULH/MULHSU/MULHU compute a full 64-bit signed/unsigned product in one cycle in IDLE and go straight to DONE, giving latency 1.
  - Divide ops are unchanged.
- When undefined: multiply uses the 32-cycle shift-add path, latency 33, and no 32x32 multiplier is inferred.

Test Plan:
- DIVU a=100, b=7 -> resp_result=14 with resp_valid rising 33 cycles after accept; REMU same operands -> 2.
- REM a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD (-3).
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at latency 1; DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0; MULHSU same operands -> 0xFFFFFFFF; MUL same operands -> 0x00000001.
- Backpressure and flush:
  - Hold resp_ready=0 for 10 cycles after resp_valid -> resp_result stable and req_ready=0 throughout.
  - Assert flush at CALC cycle 15 -> IDLE next cycle, no resp_valid, and the next request completes correctly.
- Assert rst asynchronously mid-CALC -> resp_valid=0 and busy=0 immediately; with MULDIV_ITER_FAST_MUL_EN defined, MUL 6*7 -> 42 at latency 1.
